// File: rtl/sipo_pkg.sv
// sipo_pkg: shared definitions for the serial-in / parallel-out collector.
//   SIPO_DEFAULT_WIDTH : default data bits per assembled word
//   sipo_state_e       : collect FSM states (IDLE = no bits held, COLLECT = partial frame)
package sipo_pkg;

    localparam int SIPO_DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } sipo_state_e;

endpackage

// File: rtl/sipo_out_buf.sv
// sipo_out_buf: single-entry output register with valid/ready handshake.
// A new word is taken when the register is empty or being drained on the
// same edge; otherwise the incoming word is dropped and 'drop' pulses.
//   clk, rst       : clock, synchronous active-low reset
//   load, word_in  : completed word offered by the collector
//   ready          : downstream accepts word_out when high with valid
//   word_out       : held word (stable while valid && !ready)
//   valid          : word_out holds an unconsumed word
//   drop           : combinational pulse, a loaded word was discarded
module sipo_out_buf #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] word_in,
    input  logic          ready,
    output logic [DW-1:0] word_out,
    output logic          valid,
    output logic          drop
);

    logic [DW-1:0] word_q, word_d;
    logic          valid_q, valid_d;

    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        drop    = 1'b0;
        if (load) begin
            // An accept on the same edge frees the slot for the new word.
            if (!valid_q || ready) begin
                word_d  = word_in;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_out = word_q;
    assign valid    = valid_q;

endmodule

// File: rtl/sipo_collector.sv
// sipo_collector: assembles a serial bit stream into WIDTH-bit words.
// Optional feature macro: SIPO_PARITY_EN -- each frame carries one trailing
// even-parity bit and the parity_err output is present.
//   clk, rst   : clock, synchronous active-low reset
//   shift_in   : serial data bit, sampled on edges where shift_en=1
//   shift_en   : bit strobe
//   par_out    : assembled word (MSB_FIRST=1: first bit in par_out[WIDTH-1])
//   par_valid  : par_out holds an unconsumed word
//   par_ready  : downstream accept
//   overrun    : sticky, a completed word was dropped (cleared by reset only)
//   parity_err : (SIPO_PARITY_EN only) parity check result for par_out
module sipo_collector
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_in,
    input  logic             shift_en,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
`ifdef SIPO_PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

`ifdef SIPO_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME = WIDTH + PAR_BITS;
    localparam int CW    = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);
    localparam logic [CW-1:0] DATA_END = CW'(WIDTH);
    localparam int DW    = WIDTH + PAR_BITS;

    sipo_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] shifted;
    logic             overrun_q, overrun_d;
    logic             complete;
    logic [DW-1:0]    done_word;
    logic [DW-1:0]    buf_word;
    logic             buf_drop;

    // Bit placement: MSB-first shifts left so the first bit ends at the top.
    always_comb begin
        if (MSB_FIRST) shifted = {sr_q[WIDTH-2:0], shift_in};
        else           shifted = {shift_in, sr_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        complete = 1'b0;
        if (shift_en) begin
            // The parity bit is checked, not stored, so data stops shifting after WIDTH bits.
            if (cnt_q < DATA_END) sr_d = shifted;
            case (state_q)
                IDLE: begin
                    cnt_d   = CW'(1);
                    state_d = COLLECT;
                end
                COLLECT: begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d    = '0;
                        state_d  = IDLE;
                        complete = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

`ifdef SIPO_PARITY_EN
    // Completing edge samples the parity bit; data already sits in sr_q.
    assign done_word = {(^sr_q) ^ shift_in, sr_q};
`else
    assign done_word = shifted;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            overrun_q <= overrun_d;
        end
    end

    assign overrun_d = overrun_q | buf_drop;

    sipo_out_buf #(.DW(DW)) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (complete),
        .word_in  (done_word),
        .ready    (par_ready),
        .word_out (buf_word),
        .valid    (par_valid),
        .drop     (buf_drop)
    );

    assign par_out = buf_word[WIDTH-1:0];
`ifdef SIPO_PARITY_EN
    assign parity_err = buf_word[WIDTH];
`endif
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_collector.sv
// Bench for sipo_collector: two instances (W=4 MSB-first, W=5 LSB-first) fed
// the same stream, compared every cycle against a frame-level reference model.
module tb_sipo_collector;

`ifdef SIPO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic shift_in = 1'b0;
    logic shift_en = 1'b0;
    logic par_ready = 1'b0;

    logic [3:0] po0;
    logic [4:0] po1;
    logic pv0, pv1, ov0, ov1;
`ifdef SIPO_PARITY_EN
    logic pe0, pe1;
`endif

    always #5 clk = ~clk;

    sipo_collector #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .shift_in(shift_in), .shift_en(shift_en),
        .par_out(po0), .par_valid(pv0), .par_ready(par_ready),
`ifdef SIPO_PARITY_EN
        .parity_err(pe0),
`endif
        .overrun(ov0)
    );

    sipo_collector #(.WIDTH(5), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .shift_in(shift_in), .shift_en(shift_en),
        .par_out(po1), .par_valid(pv1), .par_ready(par_ready),
`ifdef SIPO_PARITY_EN
        .parity_err(pe1),
`endif
        .overrun(ov1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: list of received bits per frame, word built on completion.
    int  m_w[2]   = '{4, 5};
    bit  m_msb[2] = '{1'b1, 1'b0};
    int  fbits[2][8];
    int  fcnt[2];
    int  ew[2];
    bit  ev[2], eo[2], ep[2];

    task automatic model_edge(input bit r, input bit en, input bit b, input bit rdy);
        for (int i = 0; i < 2; i++) begin
            if (!r) begin
                fcnt[i] = 0; ew[i] = 0; ev[i] = 0; eo[i] = 0; ep[i] = 0;
            end else begin
                bit done = 0;
                int w = 0;
                bit p = 0;
                if (en) begin
                    fbits[i][fcnt[i]] = int'(b);
                    fcnt[i]++;
                    if (fcnt[i] == m_w[i] + PAR) begin
                        done = 1;
                        for (int k = 0; k < m_w[i]; k++)
                            w += m_msb[i] ? fbits[i][k] * (1 << (m_w[i] - 1 - k))
                                          : fbits[i][k] * (1 << k);
                        for (int k = 0; k < m_w[i] + PAR; k++)
                            p ^= fbits[i][k][0];
                        fcnt[i] = 0;
                    end
                end
                if (done) begin
                    if (!ev[i] || rdy) begin
                        ew[i] = w; ev[i] = 1; ep[i] = (PAR != 0) ? p : 1'b0;
                    end else begin
                        eo[i] = 1;
                    end
                end else if (ev[i] && rdy) begin
                    ev[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("po0", 32'(po0), 32'(ew[0]));
        chk("pv0", 32'(pv0), 32'(ev[0]));
        chk("ov0", 32'(ov0), 32'(eo[0]));
        chk("po1", 32'(po1), 32'(ew[1]));
        chk("pv1", 32'(pv1), 32'(ev[1]));
        chk("ov1", 32'(ov1), 32'(eo[1]));
`ifdef SIPO_PARITY_EN
        chk("pe0", 32'(pe0), 32'(ep[0]));
        chk("pe1", 32'(pe1), 32'(ep[1]));
`endif
    endtask

    task automatic cyc(input bit r, input bit en, input bit b, input bit rdy);
        rst = r; shift_en = en; shift_in = b; par_ready = rdy;
        @(posedge clk);
        model_edge(r, en, b, rdy);
        #1;
        check_all();
    endtask

    // Send a 4-bit word first-bit = v[3], plus correct even parity when enabled.
    // rdy_last applies to the completing edge, rdy to the others; gaps inserts idle cycles.
    task automatic send4(input logic [3:0] v, input bit rdy, input bit rdy_last, input bit gaps);
        logic [4:0] fr;
        int n;
        fr = {v, ^v};
        n  = 4 + PAR;
        for (int k = 0; k < n; k++) begin
            if (gaps) cyc(1'b1, 1'b0, ~fr[4-k], rdy);
            cyc(1'b1, 1'b1, fr[4-k], (k == n - 1) ? rdy_last : rdy);
        end
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        do_reset();
        chk("rst_pv0", 32'(pv0), 32'd0);
        chk("rst_po0", 32'(po0), 32'd0);
        chk("rst_ov0", 32'(ov0), 32'd0);

        // Basic word, ready high; valid one cycle then drained.
        send4(4'b1011, 1'b1, 1'b1, 1'b0);
        chk("basic_word", 32'(po0), 32'hB);
        chk("basic_valid", 32'(pv0), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("basic_drain", 32'(pv0), 32'd0);

        // Enable low on alternate cycles.
        do_reset();
        send4(4'b1011, 1'b1, 1'b1, 1'b1);
        chk("gap_word", 32'(po0), 32'hB);
        chk("gap_valid", 32'(pv0), 32'd1);

        // Stalled downstream: second word dropped.
        do_reset();
        send4(4'b1011, 1'b0, 1'b0, 1'b0);
        send4(4'b0110, 1'b0, 1'b0, 1'b0);
        chk("ovr_word", 32'(po0), 32'hB);
        chk("ovr_flag", 32'(ov0), 32'd1);
        chk("ovr_valid", 32'(pv0), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("ovr_sticky", 32'(ov0), 32'd1);

        // Accept on the completing edge replaces the pending word.
        do_reset();
        send4(4'b1011, 1'b0, 1'b0, 1'b0);
        send4(4'b0110, 1'b0, 1'b1, 1'b0);
        chk("swap_word", 32'(po0), 32'h6);
        chk("swap_valid", 32'(pv0), 32'd1);
        chk("swap_ovr", 32'(ov0), 32'd0);

        // Reset mid-word discards the partial frame.
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        send4(4'b0011, 1'b1, 1'b1, 1'b0);
        chk("midrst_word", 32'(po0), 32'h3);
        chk("midrst_ovr", 32'(ov0), 32'd0);

        // Reset drops a pending word.
        send4(4'b1100, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_pending", 32'(pv0), 32'd0);

`ifdef SIPO_PARITY_EN
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("par_ok", 32'(pe0), 32'd0);
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("par_bad", 32'(pe0), 32'd1);
        chk("par_bad_word", 32'(po0), 32'hB);
`endif

        // Random traffic with occasional resets and stall phases.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit r, en, b, rdy;
            r   = ($urandom_range(0, 199) != 0);
            en  = ($urandom_range(0, 2) != 0);
            b   = 1'($urandom);
            rdy = ((c / 64) % 3 == 2) ? 1'b0 : 1'($urandom);
            cyc(r, en, b, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sipo_collector.md
SIPO_COLLECTOR -- requirements
Module: sipo_collector

Interface
REQ-001 Parameter WIDTH, default 4: data bits per word, minimum 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first received bit lands in par_out[WIDTH-1]; 0 means it lands in par_out[0].
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 shift_in  input  1  serial data bit from the upstream shifter.
REQ-006 shift_en  input  1  shift_in is sampled on this edge when high.
REQ-007 par_out  output  WIDTH  assembled word.
REQ-008 par_valid  output  1  par_out holds an unconsumed word.
REQ-009 par_ready  input  1  downstream accepts the word when high together with par_valid.
REQ-010 overrun  output  1  sticky flag: a completed word was dropped.
REQ-011 parity_err  output  1  present only with SIPO_PARITY_EN; qualifies par_out.

Function
REQ-012 Edges with shift_en=1 shall sample shift_in into the shift register and increment the bit counter; edges with shift_en=0 shall leave both unchanged.
REQ-013 The collect FSM shall have 2 states:
  - IDLE: counter=0.
  - COLLECT: 0 < counter < FRAME, where FRAME=WIDTH, or WIDTH+1 with parity.
REQ-014 On the edge sampling bit FRAME, the counter shall wrap to 0, the FSM shall return to IDLE, and the word shall complete.
REQ-015 A completed word shall be copied to the output register; par_valid shall be high in the cycle after the completing edge (latency 1 cycle from the last bit).
REQ-016 par_out and parity_err shall stay stable while par_valid=1 and par_ready=0.
REQ-017 par_valid&&par_ready with no completion on the same edge shall clear par_valid on that edge.
REQ-018 Completion on the same edge as an accept shall load the new word, and par_valid shall stay 1 with no overrun.
REQ-019 Completion while par_valid=1 and par_ready=0 shall drop the new word, keep the old word, and set overrun.
REQ-020 overrun shall clear only on reset.
REQ-021 Collection shall continue regardless of par_valid/par_ready; the shift register and output register are independent buffers.

Reset
REQ-022 While rst=0 at an edge:
  - par_out=0, par_valid=0, overrun=0, parity_err=0.
  - counter=0, FSM=IDLE.
REQ-023 Reset mid-word shall discard the partial word; the first enabled bit after reset release shall be bit 1 of a new word.
REQ-024 Reset shall discard a pending unaccepted output word.

Configuration
REQ-025 Macro SIPO_PARITY_EN: when defined, each frame shall be WIDTH data bits followed by one even-parity bit.
REQ-026 With SIPO_PARITY_EN:
  - parity_err=1 when the XOR of the data bits and the parity bit is 1.
  - The word shall still be delivered.
  - parity_err shall be updated together with par_out.
REQ-027 Without SIPO_PARITY_EN: the parity_err port shall not exist, and FRAME=WIDTH.

Structure
REQ-028 Package sipo_pkg shall hold the FSM state typedef (IDLE, COLLECT) and the constant SIPO_DEFAULT_WIDTH=4.
REQ-029 The output register and handshake logic shall be one sub-module, sipo_out_buf (inputs: load, word, ready; outputs: word, valid, drop).

Verification
REQ-030 Reset release; bits 1,0,1,1 with shift_en=1, MSB_FIRST=1, par_ready=1 -> par_out=4'b1011 and par_valid=1 exactly one cycle after the 4th bit, then 0 next cycle.
REQ-031 Same bits with shift_en low on alternate cycles -> par_out=4'b1011; counter advances only on enabled edges.
REQ-032 par_ready=0; words 1011 then 0110 -> par_out stays 1011, overrun=1 after the second completion, par_valid stays 1.
REQ-033 par_ready=1 on the edge the 0110 word completes while 1011 is pending -> par_out=0110 next cycle, par_valid stays 1, overrun=0.
REQ-034 Bits 1,1 then rst=0 for one cycle, then 0,0,1,1 -> single word par_out=4'b0011, overrun=0.
REQ-035 SIPO_PARITY_EN defined:
  - 1011 followed by parity bit 1 -> parity_err=0.
  - 1011 followed by parity bit 0 -> parity_err=1, par_out=1011.
